// File: rtl/generated_clock_pins_pkg.sv
// Shared mode encoding and the per-bit combine operator for the generated-clock
// pin-capture block.
package generated_clock_pkg;

  typedef enum logic [1:0] {
    MODE_OR   = 2'd0,
    MODE_AND  = 2'd1,
    MODE_XOR  = 2'd2,
    MODE_HOLD = 2'd3
  } mode_t;

  // HOLD never reaches a capture, so its result value is irrelevant.
  function automatic logic combine(input mode_t mode, input logic a, input logic b);
    logic r;
    case (mode)
      MODE_OR:   r = a | b;
      MODE_AND:  r = a & b;
      MODE_XOR:  r = a ^ b;
      MODE_HOLD: r = 1'b0;
      default:   r = 1'b0;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/generated_clock_pins_if.sv
// Control, pin-bus and result signals of generated_clock_pins; the master side
// drives divider/pin inputs, the slave side is the block itself.
interface generated_clock_pins_if #(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DIV_W  = 4,
  parameter int TICK_W = 16
);
  logic [DIV_W-1:0]        div_ratio;
  logic                    div_load;
  logic [1:0]              mode;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*WIDTH-1:0] pin_a;
  logic [NUM_CH*WIDTH-1:0] pin_b;
  logic                    div_clk;
  logic                    div_tick;
  logic [NUM_CH*WIDTH-1:0] out;
  logic [NUM_CH-1:0]       out_valid;
  logic [TICK_W-1:0]       tick_count;

  modport master (
    output div_ratio, div_load, mode, ch_en, pin_a, pin_b,
    input  div_clk, div_tick, out, out_valid, tick_count
  );

  modport slave (
    input  div_ratio, div_load, mode, ch_en, pin_a, pin_b,
    output div_clk, div_tick, out, out_valid, tick_count
  );
endinterface

// File: rtl/generated_clock_pins_pin_channel.sv
// One pin channel: on a capture edge, registers the mode-selected combination of
// its two pin slices and strobes valid for one cycle.
module pin_channel
  import generated_clock_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             capture,
  input  logic             en,
  input  mode_t            mode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] out,
  output logic             valid
);

  logic [WIDTH-1:0] comb_s;
  logic             load_s;

  // Bitwise combine of the pin slices and the capture qualifier.
  always_comb begin
    comb_s = '0;
    for (int i = 0; i < WIDTH; i++) begin
      comb_s[i] = combine(mode, a[i], b[i]);
    end
    load_s = capture && en && (mode != MODE_HOLD);
  end

  // Captured value holds between captures; valid is a single-cycle strobe.
  always_ff @(posedge clk) begin
    if (rst) begin
      out   <= '0;
      valid <= 1'b0;
    end else if (load_s) begin
      out   <= comb_s;
      valid <= 1'b1;
    end else begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/generated_clock_pins.sv
// Programmable divide-by-N generated clock with a saturating tick counter and
// NUM_CH pin channels that capture on each divided tick.
module generated_clock_pins
  import generated_clock_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int WIDTH  = 8,
  parameter int DIV_W  = 4,
  parameter int TICK_W = 16
) (
  input logic                  clk,
  input logic                  rst,
  generated_clock_pins_if.slave bus
);

  localparam logic [DIV_W-1:0]  RATIO_ONE = {{(DIV_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] TICK_ONE  = {{(TICK_W-1){1'b0}}, 1'b1};
  localparam logic [TICK_W-1:0] TICK_MAX  = {TICK_W{1'b1}};

  logic [DIV_W-1:0]        ratio_r;
  logic [DIV_W-1:0]        cnt_r;
  logic                    div_clk_r;
  logic                    div_tick_r;
  logic [TICK_W-1:0]       tick_count_r;
  logic                    terminal_s;
  mode_t                   mode_s;
  logic [NUM_CH*WIDTH-1:0] out_s;
  logic [NUM_CH-1:0]       valid_s;

  // A load on the terminal cycle suppresses the tick, capture and toggle.
  always_comb begin
    terminal_s = !bus.div_load && (cnt_r == (ratio_r - RATIO_ONE));
    mode_s     = mode_t'(bus.mode);
  end

  // Divider counter, generated clock and saturating tick counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      ratio_r      <= RATIO_ONE;
      cnt_r        <= '0;
      div_clk_r    <= 1'b0;
      div_tick_r   <= 1'b0;
      tick_count_r <= '0;
    end else if (bus.div_load) begin
      ratio_r    <= (bus.div_ratio == '0) ? RATIO_ONE : bus.div_ratio;
      cnt_r      <= '0;
      div_tick_r <= 1'b0;
    end else if (terminal_s) begin
      cnt_r      <= '0;
      div_tick_r <= 1'b1;
      div_clk_r  <= ~div_clk_r;
      if (tick_count_r != TICK_MAX) begin
        tick_count_r <= tick_count_r + TICK_ONE;
      end
    end else begin
      cnt_r      <= cnt_r + RATIO_ONE;
      div_tick_r <= 1'b0;
    end
  end

  for (genvar k = 0; k < NUM_CH; k++) begin : g_ch
    pin_channel #(
      .WIDTH(WIDTH)
    ) u_ch (
      .clk    (clk),
      .rst    (rst),
      .capture(terminal_s),
      .en     (bus.ch_en[k]),
      .mode   (mode_s),
      .a      (bus.pin_a[k*WIDTH +: WIDTH]),
      .b      (bus.pin_b[k*WIDTH +: WIDTH]),
      .out    (out_s[k*WIDTH +: WIDTH]),
      .valid  (valid_s[k])
    );
  end

  assign bus.div_clk    = div_clk_r;
  assign bus.div_tick   = div_tick_r;
  assign bus.tick_count = tick_count_r;
  assign bus.out        = out_s;
  assign bus.out_valid  = valid_s;

endmodule

// File: doc/generated_clock_pins.md
Name: generated_clock_pins

Overview:
Parametrised successor to the single-pin clock benchmark block. It contains a programmable divide-by-N counter that produces a generated clock (div_clk) and a one-cycle tick. It also has NUM_CH pin channels, each WIDTH bits wide, that capture a mode-selected combination of two pin buses on every tick. It serves as a timing-benchmark netlist for create_generated_clock and multi-pin create_clock constraints, and is one level above the pin-capture leaf.

Parameters:
NUM_CH, 4, number of pin channels
WIDTH, 8, bits per channel
DIV_W, 4, width of the divide-ratio input and counter
TICK_W, 16, width of the saturating tick counter

Ports:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous reset, active-high
div_ratio  in  DIV_W  divide ratio; a value of 0 is treated as 1
div_load  in  1  load div_ratio into the ratio register
mode  in  2  channel combine op: 0 OR, 1 AND, 2 XOR, 3 HOLD
ch_en  in  NUM_CH  per-channel capture enable
pin_a  in  NUM_CH*WIDTH  first pin bus; channel k occupies bits [k*WIDTH +: WIDTH]
pin_b  in  NUM_CH*WIDTH  second pin bus; same packing as pin_a
div_clk  out  1  generated clock, registered toggle
div_tick  out  1  one-cycle pulse per divided period
out  out  NUM_CH*WIDTH  captured channel values
out_valid  out  NUM_CH  per-channel one-cycle capture strobe
tick_count  out  TICK_W  saturating count of ticks since reset

Behaviour:
- Reset, on the posedge with rst=1: ratio_reg=1, cnt=0, div_clk=0, div_tick=0, out=0, out_valid=0, tick_count=0. rst overrides every other input, including mid-period.
- Load: on a posedge with div_load=1:
  - ratio_reg <= (div_ratio==0 ? 1 : div_ratio), cnt <= 0.
  - div_tick <= 0 and out_valid <= 0; no capture occurs.
  - div_clk holds its value.
- Terminal: on a posedge with div_load=0 and cnt==ratio_reg-1:
  - cnt <= 0, div_tick <= 1, div_clk <= ~div_clk.
  - tick_count <= tick_count+1, saturating at all-ones.
- Otherwise: cnt <= cnt+1, div_tick <= 0, out_valid <= 0.
- Resulting timing: the tick period is ratio_reg cycles and the div_clk period is 2*ratio_reg cycles. With ratio 1, div_tick stays high continuously and div_clk toggles every cycle (clk/2).
- Capture happens on the terminal edge only. For each channel k with ch_en[k]=1 and mode!=HOLD:
  - out[k] <= op(pin_a[k], pin_b[k]) and out_valid[k] <= 1.
  - Disabled channels, and all channels in HOLD, keep out[k] and set out_valid[k]=0.
- Latency: pins are sampled at the terminal edge. The result appears in the cycle after that edge, coincident with div_tick.
- Simultaneous div_load and terminal count: the load wins. There is no tick, no capture and no toggle.
- Changing mode or ch_en mid-period has no effect until the next terminal edge.
- The ratio register holds indefinitely. div_ratio is ignored whenever div_load=0.

Decomposition:
- Package generated_clock_pkg:
  - mode constants MODE_OR=0, MODE_AND=1, MODE_XOR=2, MODE_HOLD=3
  - function combine(mode, a, b)
- Sub-module pin_channel (WIDTH):
  - inputs: clk, rst, capture, en, mode, a, b
  - outputs: out, valid
  - instantiated NUM_CH times through a generate loop
- The divider counter, div_clk and tick_count stay in the top module.

Test Plan:
- Assert rst for 2 cycles, then release with no load -> div_tick=1 every cycle, div_clk toggles every cycle, tick_count increments by 1 per cycle.
- Pulse div_load with div_ratio=3 -> div_tick pulses on cycles 3, 6, 9 after the load; div_clk period is 6 cycles; tick_count increments once per 3 cycles.
- Ratio 2, mode=OR, ch_en=4'b1111, pin_a ch0=0x0F, pin_b ch0=0xF0 -> out ch0=0xFF and out_valid=4'b1111 together with div_tick. With mode=AND, the next tick gives out ch0=0x00.
- Mode=XOR, ch_en=4'b0101, pin_a=pin_b^0xFF per channel -> channels 0 and 2 read 0xFF with valid set; channels 1 and 3 keep their prior value with valid clear. With mode=HOLD, no channel updates.
- Raise div_load with div_ratio=0 on a terminal cycle -> no tick on that edge and ratio_reg=1; ticks resume every cycle afterwards.
- Assert rst mid-period at ratio 5 with cnt=3 -> the next cycle shows every output at its reset value, and ticks resume every cycle (ratio 1).
